// File: rtl/riscv_bp_pkg.sv
// Shared constants for branch resolution: PC-select codes, branch funct3 codes
// and the 2-bit predictor counter encoding with its saturating update rule.
package riscv_bp_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ     = 2'b00,
        PCSRC_TARGET  = 2'b01,
        PCSRC_JALR    = 2'b10,
        PCSRC_RECOVER = 2'b11
    } pc_src_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    function automatic logic [1:0] bht_sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == BHT_ST) ? BHT_ST : ctr + 2'd1;
        else
            return (ctr == BHT_SNT) ? BHT_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2^IDX_W two-bit saturating counters, one combinational
// read port that sees a same-cycle write, one registered update port.
module bht_table
    import riscv_bp_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0] ctr_q [DEPTH];
    logic [1:0] wr_ctr_d;

    assign wr_ctr_d = bht_sat_update(ctr_q[wr_idx_i], wr_taken_i);
    assign rd_ctr_o = (wr_en_i && (rd_idx_i == wr_idx_i)) ? wr_ctr_d : ctr_q[rd_idx_i];

    // NOTE: the table is reset entry-by-entry because predictions must start at
    // weak not-taken; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= BHT_WNT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_bp.sv
// Branch resolution with a 2-bit dynamic predictor: ID lookup, EX resolve,
// PC-select/flush and BHT training. Optional counters under BRANCH_STATS_EN.
module branch_resolve_bp
    import riscv_bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int STAT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_branch,
    input  logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_op3,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_Z,
    input  logic            ex_S,
    input  logic            ex_U,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    output logic [1:0]      pc_src,
    output logic            flush,
    output logic            branch_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
`endif
);

    logic [BHT_IDX_W-1:0] id_idx;
    logic [BHT_IDX_W-1:0] ex_idx;
    logic [1:0]           id_ctr;
    logic                 cond;
    logic                 upd_en;
    pc_src_e              pc_sel;

    assign id_idx = id_pc[BHT_IDX_W+1:2];
    assign ex_idx = ex_pc[BHT_IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{id_pc[XLEN-1:BHT_IDX_W+2], id_pc[1:0],
                              ex_pc[XLEN-1:BHT_IDX_W+2], ex_pc[1:0]};

    // A jump sharing the cycle with ex_branch must not train the predictor.
    assign upd_en = ex_valid && ex_branch && !ex_jump;

    bht_table #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (id_idx),
        .rd_ctr_o   (id_ctr),
        .wr_en_i    (upd_en),
        .wr_idx_i   (ex_idx),
        .wr_taken_i (cond)
    );

    assign id_pred_taken = id_valid && id_branch && id_ctr[1];

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            F3_BEQ:  cond = ex_Z;
            F3_BNE:  cond = !ex_Z;
            F3_BLT:  cond = ex_S;
            F3_BGE:  cond = !ex_S;
            F3_BLTU: cond = ex_U;
            F3_BGEU: cond = !ex_U;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = ex_valid && ex_branch && cond;

    // A correctly predicted taken branch was already redirected in ID.
    always_comb begin
        pc_sel = PCSRC_SEQ;
        if (ex_valid) begin
            if (ex_jump) begin
                pc_sel = ex_op3 ? PCSRC_TARGET : PCSRC_JALR;
            end else if (ex_branch) begin
                if (cond && !ex_pred_taken)
                    pc_sel = PCSRC_TARGET;
                else if (!cond && ex_pred_taken)
                    pc_sel = PCSRC_RECOVER;
            end
        end
    end

    assign pc_src = pc_sel;
    assign flush  = (pc_sel != PCSRC_SEQ);

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_br_q, stat_br_d;
    logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (upd_en) begin
            if (stat_br_q != '1)
                stat_br_d = stat_br_q + STAT_W'(1);
            if ((cond != ex_pred_taken) && (stat_mis_q != '1))
                stat_mis_d = stat_mis_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    logic [STAT_W-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_bp.sv
// Self-checking bench for branch_resolve_bp: directed scenarios plus randomized
// traffic against an operand-level reference model of the predictor.
module tb_branch_resolve_bp;

    localparam int XLEN   = 32;
    localparam int IDX_W  = 6;
    localparam int STAT_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_branch;
    logic [XLEN-1:0] id_pc;
    logic            id_pred_taken;
    logic            ex_valid, ex_branch, ex_jump, ex_op3;
    logic [2:0]      ex_funct3;
    logic            ex_Z, ex_S, ex_U;
    logic [XLEN-1:0] ex_pc;
    logic            ex_pred_taken;
    logic [1:0]      pc_src;
    logic            flush, branch_taken;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_branches, stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int mdl_bht [64];
    bit cur_taken;
    int mdl_br, mdl_mis;

    branch_resolve_bp #(.XLEN(XLEN), .BHT_IDX_W(IDX_W), .STAT_W(STAT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_branch     (id_branch),
        .id_pc         (id_pc),
        .id_pred_taken (id_pred_taken),
        .ex_valid      (ex_valid),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_op3        (ex_op3),
        .ex_funct3     (ex_funct3),
        .ex_Z          (ex_Z),
        .ex_S          (ex_S),
        .ex_U          (ex_U),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .pc_src        (pc_src),
        .flush         (flush),
        .branch_taken  (branch_taken)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic int sat_step(int v, bit t);
        if (t) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    function automatic int pc_idx(logic [XLEN-1:0] pc);
        return int'(pc[7:2]);
    endfunction

    // Branch condition from ALU flags, as the ISA table defines it.
    function automatic bit flags_cond(logic [2:0] f3, logic z, logic s, logic u);
        case (f3)
            3'b000: return z;
            3'b001: return !z;
            3'b100: return s;
            3'b101: return !s;
            3'b110: return u;
            3'b111: return !u;
            default: return 1'b0;
        endcase
    endfunction

    // Branch condition directly from the compared operands.
    function automatic bit operand_cond(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] exp_pc_src();
        if (!ex_valid) return 2'd0;
        if (ex_jump) return ex_op3 ? 2'd1 : 2'd2;
        if (ex_branch && cur_taken && !ex_pred_taken) return 2'd1;
        if (ex_branch && !cur_taken && ex_pred_taken) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit exp_pred();
        int v;
        v = mdl_bht[pc_idx(id_pc)];
        if (ex_valid && ex_branch && !ex_jump && pc_idx(ex_pc) == pc_idx(id_pc))
            v = sat_step(v, cur_taken);
        return id_valid && id_branch && (v >= 2);
    endfunction

    task automatic tick();
        if (rst) begin
            foreach (mdl_bht[i]) mdl_bht[i] = 1;
            mdl_br  = 0;
            mdl_mis = 0;
        end else if (ex_valid && ex_branch && !ex_jump) begin
            mdl_bht[pc_idx(ex_pc)] = sat_step(mdl_bht[pc_idx(ex_pc)], cur_taken);
            mdl_br++;
            if (cur_taken != ex_pred_taken) mdl_mis++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_op3 = 0; ex_funct3 = 3'b000;
        ex_Z = 0; ex_S = 0; ex_U = 0; ex_pc = '0; ex_pred_taken = 0; cur_taken = 0;
    endtask

    task automatic drive_branch(logic [31:0] pc, logic [2:0] f3, logic z, logic s, logic u, logic pred);
        ex_valid = 1; ex_branch = 1; ex_jump = 0; ex_op3 = 0; ex_funct3 = f3;
        ex_Z = z; ex_S = s; ex_U = u; ex_pc = pc; ex_pred_taken = pred;
        cur_taken = flags_cond(f3, z, s, u);
    endtask

    task automatic lookup(logic [31:0] pc);
        id_valid = 1; id_branch = 1; id_pc = pc;
    endtask

    task automatic do_reset();
        ex_idle();
        id_valid = 0; id_branch = 0; id_pc = '0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        lookup(32'h100);
        #1;
        n_checks++;
        if (id_pred_taken !== 1'b0) begin
            n_errors++; $display("FAIL reset_pred: got %b want 0", id_pred_taken);
        end
        n_checks++;
        if (pc_src !== 2'b00 || flush !== 1'b0 || branch_taken !== 1'b0) begin
            n_errors++; $display("FAIL reset_idle: got pc_src=%b flush=%b taken=%b want 00/0/0", pc_src, flush, branch_taken);
        end
    endtask

    task automatic test_training();
        drive_branch(32'h100, 3'b000, 1, 0, 0, 0);
        lookup(32'h104);
        #1;
        n_checks++;
        if (pc_src !== 2'b01 || flush !== 1'b1 || branch_taken !== 1'b1) begin
            n_errors++; $display("FAIL train_mispred_taken: got pc_src=%b flush=%b taken=%b want 01/1/1", pc_src, flush, branch_taken);
        end
        tick();
        ex_idle();
        lookup(32'h100);
        #1;
        n_checks++;
        if (id_pred_taken !== 1'b1) begin
            n_errors++; $display("FAIL train_pred_after: got %b want 1", id_pred_taken);
        end
        drive_branch(32'h100, 3'b000, 1, 0, 0, 1);
        lookup(32'h104);
        #1;
        n_checks++;
        if (pc_src !== 2'b00 || flush !== 1'b0 || branch_taken !== 1'b1) begin
            n_errors++; $display("FAIL train_correct_taken: got pc_src=%b flush=%b taken=%b want 00/0/1", pc_src, flush, branch_taken);
        end
        tick();
    endtask

    task automatic test_recovery_saturation();
        bit exp_seq [6] = '{1, 0, 0, 0, 0, 1};
        drive_branch(32'h100, 3'b001, 1, 0, 0, 1);
        lookup(32'h104);
        #1;
        n_checks++;
        if (pc_src !== 2'b11 || flush !== 1'b1 || branch_taken !== 1'b0) begin
            n_errors++; $display("FAIL recover: got pc_src=%b flush=%b taken=%b want 11/1/0", pc_src, flush, branch_taken);
        end
        // From 11: NT, NT, NT, NT, then T, T -> predictions 1,0,0,0,0,1.
        for (int i = 0; i < 6; i++) begin
            if (i > 0) drive_branch(32'h100, 3'b001, (i < 4), 0, 0, 0);
            tick();
            ex_idle();
            lookup(32'h100);
            #1;
            n_checks++;
            if (id_pred_taken !== exp_seq[i]) begin
                n_errors++; $display("FAIL saturate_step%0d: got %b want %b", i, id_pred_taken, exp_seq[i]);
            end
        end
    endtask

    task automatic test_jumps_gating();
        // Entry for 0x100 now holds 10 (predict taken).
        drive_branch(32'h100, 3'b000, 0, 0, 0, 0);
        ex_jump = 1; ex_op3 = 1;
        lookup(32'h100);
        #1;
        n_checks++;
        if (pc_src !== 2'b01 || flush !== 1'b1 || id_pred_taken !== 1'b1) begin
            n_errors++; $display("FAIL jal: got pc_src=%b flush=%b pred=%b want 01/1/1", pc_src, flush, id_pred_taken);
        end
        tick();
        ex_op3 = 0;
        #1;
        n_checks++;
        if (pc_src !== 2'b10 || flush !== 1'b1 || id_pred_taken !== 1'b1) begin
            n_errors++; $display("FAIL jalr: got pc_src=%b flush=%b pred=%b want 10/1/1", pc_src, flush, id_pred_taken);
        end
        tick();
        drive_branch(32'h100, 3'b000, 0, 0, 0, 1);
        ex_valid = 0; ex_jump = 1; ex_op3 = 1;
        #1;
        n_checks++;
        if (pc_src !== 2'b00 || flush !== 1'b0 || branch_taken !== 1'b0) begin
            n_errors++; $display("FAIL ex_invalid: got pc_src=%b flush=%b taken=%b want 00/0/0", pc_src, flush, branch_taken);
        end
        tick();
        ex_idle();
        #1;
        n_checks++;
        if (id_pred_taken !== 1'b1) begin
            n_errors++; $display("FAIL jump_no_update: got %b want 1", id_pred_taken);
        end
    endtask

    task automatic test_bypass_invalid_f3();
        drive_branch(32'h14, 3'b000, 1, 0, 0, 0);
        lookup(32'h14);
        #1;
        n_checks++;
        if (id_pred_taken !== 1'b1) begin
            n_errors++; $display("FAIL bypass: got %b want 1", id_pred_taken);
        end
        tick();
        drive_branch(32'h18, 3'b010, 1, 1, 1, 1);
        #1;
        n_checks++;
        if (branch_taken !== 1'b0 || pc_src !== 2'b11) begin
            n_errors++; $display("FAIL f3_010: got taken=%b pc_src=%b want 0/11", branch_taken, pc_src);
        end
        tick();
        drive_branch(32'h18, 3'b011, 0, 1, 1, 0);
        #1;
        n_checks++;
        if (branch_taken !== 1'b0 || pc_src !== 2'b00) begin
            n_errors++; $display("FAIL f3_011: got taken=%b pc_src=%b want 0/00", branch_taken, pc_src);
        end
        tick();
        ex_idle();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  f3;
        logic [1:0]  want_src;
        int errs_before;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
            if ($urandom_range(0, 1) == 1) b[31] = ~a[31];
            f3 = 3'($urandom_range(0, 7));
            ex_valid      = ($urandom_range(0, 9) != 0);
            ex_jump       = ($urandom_range(0, 7) == 0);
            ex_branch     = ($urandom_range(0, 5) != 0);
            ex_op3        = 1'($urandom_range(0, 1));
            ex_funct3     = f3;
            ex_Z          = (a == b);
            ex_S          = ($signed(a) < $signed(b));
            ex_U          = (a < b);
            ex_pc         = {$urandom_range(0, 255), 6'd0, 2'($urandom_range(0, 7)), 2'd0} | (32'($urandom_range(0, 7)) << 2);
            ex_pred_taken = 1'($urandom_range(0, 1));
            cur_taken     = operand_cond(f3, a, b);
            id_valid      = ($urandom_range(0, 7) != 0);
            id_branch     = ($urandom_range(0, 3) != 0);
            id_pc         = {$urandom_range(0, 255), 8'd0} | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            #1;
            errs_before = n_errors;
            want_src = exp_pc_src();
            n_checks++;
            if (pc_src !== want_src) begin
                n_errors++; $display("FAIL rnd_pc_src[%0d]: got %b want %b", n, pc_src, want_src);
            end
            n_checks++;
            if (flush !== (want_src != 2'b00)) begin
                n_errors++; $display("FAIL rnd_flush[%0d]: got %b want %b", n, flush, want_src != 2'b00);
            end
            n_checks++;
            if (branch_taken !== (ex_valid && ex_branch && cur_taken)) begin
                n_errors++; $display("FAIL rnd_taken[%0d]: got %b want %b", n, branch_taken, ex_valid && ex_branch && cur_taken);
            end
            n_checks++;
            if (id_pred_taken !== exp_pred()) begin
                n_errors++; $display("FAIL rnd_pred[%0d]: got %b want %b", n, id_pred_taken, exp_pred());
            end
            if (n_errors - errs_before > 0 && n_errors > 20) break;
            tick();
        end
        ex_idle();
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        bit mis [10] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            // BEQ with Z=1 is taken; a misprediction means pred=0.
            drive_branch(32'h40 + 32'(i * 4), 3'b000, 1, 0, 0, !mis[i]);
            tick();
        end
        ex_idle();
        #1;
        n_checks++;
        if (stat_branches !== STAT_W'(mdl_br) || mdl_br != 10) begin
            n_errors++; $display("FAIL stat_branches: got %0d want 10", stat_branches);
        end
        n_checks++;
        if (stat_mispredicts !== STAT_W'(mdl_mis) || mdl_mis != 3) begin
            n_errors++; $display("FAIL stat_mispredicts: got %0d want 3", stat_mispredicts);
        end
        do_reset();
        n_checks++;
        if (stat_branches !== '0 || stat_mispredicts !== '0) begin
            n_errors++; $display("FAIL stat_reset: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end
    endtask
`endif

    initial begin
        rst = 1;
        ex_idle();
        id_valid = 0; id_branch = 0; id_pc = '0;
        foreach (mdl_bht[i]) mdl_bht[i] = 1;
        mdl_br = 0;
        mdl_mis = 0;
        test_reset();
        test_training();
        test_recovery_saturation();
        test_jumps_gating();
        test_bypass_invalid_f3();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_bp.md
# branch_resolve_bp

Parametrised branch resolution unit with a 2-bit dynamic predictor, replacing the static PC-select generator in the 5-stage pipeline. It has three jobs:
- Look up a branch history table (BHT) in ID to give a taken/not-taken prediction.
- Resolve the real branch/jump outcome in EX from the ALU flags.
- Drive the PC mux select, a mispredict flush, and a registered BHT update.

The PC mux gains a fourth input, ex_pc+4, to recover from predicted-taken branches that are not taken.

## Interface
Parameters:
- XLEN, 32, PC width.
- BHT_IDX_W, 6, log2 of BHT entries (64 entries of 2 bits).
- STAT_W, 32, statistics counter width (only with BRANCH_STATS_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_branch  in  1  ID instruction is a conditional branch.
- id_pc  in  XLEN  ID instruction PC.
- id_pred_taken  out  1  prediction; 0 when !id_valid or !id_branch.
- ex_valid  in  1  EX holds a valid, non-stalled instruction.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_jump  in  1  EX instruction is JAL/JALR.
- ex_op3  in  1  1 = JAL, 0 = JALR (instruction bit 3).
- ex_funct3  in  3  branch condition.
- ex_Z, ex_S, ex_U  in  1 each  ALU flags: zero, signed-less, unsigned-less.
- ex_pc  in  XLEN  EX instruction PC (BHT index source).
- ex_pred_taken  in  1  prediction carried from ID.
- pc_src  out  2  00 sequential, 01 branch/JAL target, 10 JALR ALU result, 11 ex_pc+4 recovery.
- flush  out  1  kill IF/ID contents.
- branch_taken  out  1  actual branch outcome.
- stat_branches, stat_mispredicts  out  STAT_W  statistics (BRANCH_STATS_EN only).

## Operation
- **Index:** pc[BHT_IDX_W+1:2] for both the ID lookup and the EX update.
- **Prediction:** id_pred_taken = MSB of the indexed counter, gated by id_valid && id_branch.
- **Condition by funct3:**
  - 000 Z, 001 !Z, 100 S, 101 !S, 110 U, 111 !U.
  - 010/011 evaluate to not taken.
- **branch_taken** = ex_valid && ex_branch && condition.
- **pc_src priority, when ex_valid:**
  1. ex_jump && ex_op3 → 01 (JAL).
  2. ex_jump && !ex_op3 → 10 (JALR).
  3. ex_branch, taken && !pred → 01.
  4. ex_branch, !taken && pred → 11.
  5. Otherwise 00. ID has already redirected for a correctly predicted taken branch.
- **flush** = (pc_src != 00). Jumps always flush; there is no jump prediction.
- **ex_valid = 0** forces pc_src = 00, flush = 0, branch_taken = 0 and no BHT update, whatever the other inputs are.
- **ex_branch && ex_jump together:** jump wins, no BHT update.
- **BHT update:**
  - Only when ex_valid && ex_branch.
  - Taken: increment, saturating at 11. Not taken: decrement, saturating at 00.
  - Encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.

## Timing
- pc_src, flush and branch_taken are combinational from EX inputs, in the same cycle (0 latency).
- id_pred_taken is combinational from id_pc in the same cycle.
- The BHT write commits at the rising edge that ends the EX cycle.
- **Same-cycle bypass:** if the ID index equals a pending EX update index, id_pred_taken uses the post-update counter value.
- **Reset:**
  - Every BHT entry becomes 01 (weak not-taken) in the reset cycle.
  - The stat counters become 0.
  - The combinational outputs follow their inputs; no internal state beyond BHT/stats.
  - A pending update in the reset cycle is discarded.
- **Counter wrap:** stat counters saturate at 2^STAT_W-1 and never wrap.

## Configuration
- **BRANCH_STATS_EN defined:**
  - stat_branches increments on each valid resolved conditional branch.
  - stat_mispredicts increments when taken != ex_pred_taken.
  - Both are registered, updated on the same edge as the BHT, and saturating.
- **Undefined:** the stat ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package riscv_bp_pkg holds:
  - PCSRC_SEQ/TARGET/JALR/RECOVER = 2'b00/01/10/11.
  - Branch funct3 constants (F3_BEQ…F3_BGEU).
  - Counter constants (BHT_SNT, BHT_WNT, BHT_WT, BHT_ST).
- Sub-module bht_table:
  - 2^BHT_IDX_W × 2-bit storage with synchronous reset.
  - One combinational read port with write-bypass.
  - One registered saturating-update write port.
- The top level holds the condition decode, pc_src/flush logic and stats.

## Test plan
- **Reset default:** assert rst 1 cycle, then id_branch at pc 0x100 → id_pred_taken = 0 (entry 01).
- **Training and no-flush taken path:** BEQ at 0x100 with Z=1, pred=0 → pc_src=01, flush=1, entry becomes 10. Next lookup at 0x100 → pred=1. Repeat with pred=1, taken → pc_src=00, flush=0, entry 11.
- **Recovery and saturation:** BNE, Z=1 (not taken), pred=1 → pc_src=11, flush=1. Three not-taken resolutions from 11 give 00, and a fourth stays at 00.
- **Jumps and gating:** JAL (jump, op3=1) → 01, flush, BHT unchanged. JALR (op3=0) → 10. Same inputs with ex_valid=0 → 00, no flush.
- **Bypass and invalid funct3:**
  - EX updates index 5 to taken while ID looks up index 5 in the same cycle → id_pred_taken reflects the new value.
  - funct3 = 010 → not taken.
- **Statistics (BRANCH_STATS_EN):** 10 branches with 3 mispredicts → stat_branches = 10, stat_mispredicts = 3. Asserting rst clears both to 0.
